// File: rtl/byte_striping_param_pkg.sv
// Shared definitions for the byte striper: FSM state type, lane_sel
// encodings, default pad word and the lane-count decode with clamping.
package byte_striping_param_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } stripe_state_e;

    localparam logic [1:0] SEL_1_LANE  = 2'd0;
    localparam logic [1:0] SEL_2_LANES = 2'd1;
    localparam logic [1:0] SEL_4_LANES = 2'd2;
    localparam logic [1:0] SEL_8_LANES = 2'd3;

    localparam logic [7:0] DEFAULT_PAD = 8'h00;

    // Requested lane count for a lane_sel code, clamped to the physical lanes.
    function automatic int unsigned lanes_from_sel(input logic [1:0] sel,
                                                   input int unsigned num_lanes);
        int unsigned req;
        req = 32'd1 << sel;
        return (req > num_lanes) ? num_lanes : req;
    endfunction

    // True when lane_sel asks for more lanes than physically exist.
    function automatic logic sel_exceeds(input logic [1:0] sel,
                                         input int unsigned num_lanes);
        return (32'd1 << sel) > num_lanes;
    endfunction

endpackage

// File: rtl/byte_striping_param_stripe_lane_buf.sv
// Per-lane word buffer for one stripe. Stores the accepted word at the
// current pointer and presents the next stripe image: buffered lanes below
// the pointer, the word arriving this cycle at the pointer, pad elsewhere.
module byte_striping_param_stripe_lane_buf
    import byte_striping_param_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          NUM_LANES = 4,
    parameter int          PTR_W     = 2,
    parameter logic [DATA_W-1:0] PAD_VALUE = DATA_W'(DEFAULT_PAD)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [PTR_W-1:0]            wr_ptr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        lane_mask
);

    logic [DATA_W-1:0] lane_q [NUM_LANES];
    logic [DATA_W-1:0] lane_d [NUM_LANES];

    // Write the accepted word into the lane addressed by the pointer.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_d[k] = lane_q[k];
        end
        if (wr_en) begin
            lane_d[wr_ptr] = wr_data;
        end
    end

    // Lane storage; cleared on reset so a discarded partial leaves no trace.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!reset) begin
                lane_q[k] <= '0;
            end else begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    // Stripe image with pad insertion: the word arriving now bypasses storage.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_data[k*DATA_W +: DATA_W] = PAD_VALUE;
            lane_mask[k]                  = 1'b0;
            if (PTR_W'(k) < wr_ptr) begin
                lane_data[k*DATA_W +: DATA_W] = lane_q[k];
                lane_mask[k]                  = 1'b1;
            end else if ((PTR_W'(k) == wr_ptr) && wr_en) begin
                lane_data[k*DATA_W +: DATA_W] = wr_data;
                lane_mask[k]                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_striping_param.sv
// Byte striper top: gathers stream words into stripes of a latched lane
// count, emits whole stripes aligned in one cycle, flushes a partial stripe
// with pad when the stream goes idle mid-stripe.
module byte_striping_param
    import byte_striping_param_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          NUM_LANES = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE = DATA_W'(DEFAULT_PAD),
    parameter int          CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid,
    input  logic [DATA_W-1:0]           data,
    input  logic [1:0]                  lane_sel,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic [NUM_LANES-1:0]        valid_out,
    output logic [CNT_W-1:0]            stripe_cnt,
    output logic                        cfg_err
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    stripe_state_e               state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [PTR_W-1:0]            a_last_q, a_last_d;
    logic [NUM_LANES*DATA_W-1:0] data_out_q, data_out_d;
    logic [NUM_LANES-1:0]        valid_out_q, valid_out_d;
    logic [CNT_W-1:0]            stripe_cnt_q, stripe_cnt_d;
    logic                        cfg_err_q, cfg_err_d;

    logic [NUM_LANES*DATA_W-1:0] lane_data;
    logic [NUM_LANES-1:0]        lane_mask;
    logic [PTR_W-1:0]            cur_last;
    logic                        emit;

    byte_striping_param_stripe_lane_buf #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W),
        .PAD_VALUE (PAD_VALUE)
    ) u_lane_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (valid),
        .wr_ptr    (ptr_q),
        .wr_data   (data),
        .lane_data (lane_data),
        .lane_mask (lane_mask)
    );

    // Next-state logic: lane count comes from lane_sel only at a stripe start.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        a_last_d     = a_last_q;
        data_out_d   = data_out_q;
        valid_out_d  = '0;
        stripe_cnt_d = stripe_cnt_q;
        cfg_err_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            cur_last = PTR_W'(lanes_from_sel(lane_sel, NUM_LANES) - 1);
        end else begin
            cur_last = a_last_q;
        end

        emit = (valid && (ptr_q == cur_last)) || ((state_q == ST_FILL) && !valid);

        if ((state_q == ST_IDLE) && valid) begin
            a_last_d  = cur_last;
            cfg_err_d = sel_exceeds(lane_sel, NUM_LANES);
        end

        if (valid) begin
            if (ptr_q == cur_last) begin
                ptr_d   = '0;
                state_d = ST_IDLE;
            end else begin
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = ST_FILL;
            end
        end else if (state_q == ST_FILL) begin
            ptr_d   = '0;
            state_d = ST_IDLE;
        end

        if (emit) begin
            data_out_d   = lane_data;
            valid_out_d  = lane_mask;
            stripe_cnt_d = stripe_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset discards any partial stripe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            a_last_q     <= '0;
            data_out_q   <= '0;
            valid_out_q  <= '0;
            stripe_cnt_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            a_last_q     <= a_last_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            stripe_cnt_q <= stripe_cnt_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign stripe_cnt = stripe_cnt_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_byte_striping_param.sv
// Bench for the byte striper: directed scenarios plus a random tail, with a
// queue-based stripe model checked every cycle and literal stripe values
// pinned at the key points.
module tb_byte_striping_param;

    localparam int DATA_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 16;

    logic                        clk;
    logic                        reset;
    logic                        valid;
    logic [DATA_W-1:0]           data;
    logic [1:0]                  laneSel;
    logic [NUM_LANES*DATA_W-1:0] dataOut;
    logic [NUM_LANES-1:0]        validOut;
    logic [CNT_W-1:0]            stripeCnt;
    logic                        cfgErr;

    int checkCount;
    int errorCount;

    logic [DATA_W-1:0]           partial[$];
    int                          activeA;
    logic [NUM_LANES*DATA_W-1:0] expData;
    logic [NUM_LANES-1:0]        expValid;
    logic [CNT_W-1:0]            expCnt;
    logic                        expErr;
    bit                          checkEnable;

    bit                          litPending;
    logic [NUM_LANES*DATA_W-1:0] litData;
    logic [NUM_LANES-1:0]        litValid;
    logic [CNT_W-1:0]            litCnt;
    logic                        litErr;
    string                       litName;

    byte_striping_param #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES),
        .PAD_VALUE (8'h00),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .data       (data),
        .lane_sel   (laneSel),
        .data_out   (dataOut),
        .valid_out  (validOut),
        .stripe_cnt (stripeCnt),
        .cfg_err    (cfgErr)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Model emission: buffered words in order, pad above, count one stripe.
    task automatic emitModel();
        expData  = '0;
        expValid = '0;
        for (int i = 0; i < partial.size(); i++) begin
            expData[i*DATA_W +: DATA_W] = partial[i];
            expValid[i]                 = 1'b1;
        end
        expCnt = expCnt + 1'b1;
        partial.delete();
    endtask

    // Model of what the outputs must show after the coming clock edge.
    task automatic modelStep(input logic rst, input logic v, input logic [7:0] d, input logic [1:0] sel);
        int req;
        if (!rst) begin
            partial.delete();
            expData  = '0;
            expValid = '0;
            expCnt   = '0;
            expErr   = 1'b0;
            return;
        end
        expErr   = 1'b0;
        expValid = '0;
        if (v) begin
            if (partial.size() == 0) begin
                req     = 1 << sel;
                activeA = (req > NUM_LANES) ? NUM_LANES : req;
                expErr  = (req > NUM_LANES);
            end
            partial.push_back(d);
            if (partial.size() == activeA) emitModel();
        end else if (partial.size() != 0) begin
            emitModel();
        end
    endtask

    // Compare DUT against the model, and against a pinned literal if one is pending.
    task automatic checkOutput();
        if (!checkEnable) return;
        compare("data_out",   32'(dataOut),   32'(expData));
        compare("valid_out",  32'(validOut),  32'(expValid));
        compare("stripe_cnt", 32'(stripeCnt), 32'(expCnt));
        compare("cfg_err",    32'(cfgErr),    32'(expErr));
        if (litPending) begin
            compare({litName, ".data"},  32'(dataOut),   32'(litData));
            compare({litName, ".valid"}, 32'(validOut),  32'(litValid));
            compare({litName, ".cnt"},   32'(stripeCnt), 32'(litCnt));
            compare({litName, ".err"},   32'(cfgErr),    32'(litErr));
            litPending = 1'b0;
        end
    endtask

    // One cycle: check current outputs, then drive the inputs for the next edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d, input logic [1:0] sel);
        @(negedge clk);
        checkOutput();
        reset   = rst;
        valid   = v;
        data    = d;
        laneSel = sel;
        modelStep(rst, v, d, sel);
        checkEnable = 1'b1;
    endtask

    task automatic expectNext(input string name, input logic [31:0] d, input logic [3:0] v,
                              input logic [15:0] c, input logic e);
        litPending = 1'b1;
        litName    = name;
        litData    = d;
        litValid   = v;
        litCnt     = c;
        litErr     = e;
    endtask

    task automatic sendWords(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input int n, input logic [1:0] sel);
        logic [7:0] words [4];
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, words[i], sel);
    endtask

    // Directed scenarios followed by a random stream.
    initial begin
        checkCount  = 0;
        errorCount  = 0;
        checkEnable = 1'b0;
        litPending  = 1'b0;
        activeA     = 1;
        reset = 1'b0; valid = 1'b0; data = '0; laneSel = 2'd2;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hFF, 2'd2);
            expectNext("reset", 32'h0, 4'b0000, 16'd0, 1'b0);
        end

        sendWords(8'h01, 8'h02, 8'h04, 8'h08, 4, 2'd2);
        expectNext("full1", 32'h08040201, 4'b1111, 16'd1, 1'b0);
        sendWords(8'h10, 8'h20, 8'h40, 8'h80, 4, 2'd2);
        expectNext("full2", 32'h80402010, 4'b1111, 16'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2);
        expectNext("idle_hold", 32'h80402010, 4'b0000, 16'd2, 1'b0);

        sendWords(8'h10, 8'h20, 8'h00, 8'h00, 2, 2'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2);
        expectNext("flush", 32'h00002010, 4'b0011, 16'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2);

        applyStimulus(1'b1, 1'b1, 8'hAA, 2'd2);
        sendWords(8'hBB, 8'hCC, 8'hDD, 8'h00, 3, 2'd1);
        expectNext("sel_latched", 32'hDDCCBBAA, 4'b1111, 16'd4, 1'b0);
        sendWords(8'h11, 8'h22, 8'h00, 8'h00, 2, 2'd1);
        expectNext("two_lane", 32'h00002211, 4'b0011, 16'd5, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd1);

        applyStimulus(1'b1, 1'b1, 8'h31, 2'd3);
        expectNext("cfg_err", 32'h00002211, 4'b0000, 16'd5, 1'b1);
        sendWords(8'h32, 8'h33, 8'h34, 8'h00, 3, 2'd3);
        expectNext("clamped", 32'h34333231, 4'b1111, 16'd6, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h41, 2'd0);
        expectNext("one_lane_a", 32'h00000041, 4'b0001, 16'd7, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h42, 2'd0);
        expectNext("one_lane_b", 32'h00000042, 4'b0001, 16'd8, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h43, 2'd0);
        expectNext("one_lane_c", 32'h00000043, 4'b0001, 16'd9, 1'b0);

        sendWords(8'h01, 8'h02, 8'h03, 8'h00, 3, 2'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'd2);
        expectNext("reset_discard", 32'h0, 4'b0000, 16'd0, 1'b0);
        sendWords(8'h05, 8'h06, 8'h07, 8'h08, 4, 2'd2);
        expectNext("after_reset", 32'h08070605, 4'b1111, 16'd1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0),
                          8'($urandom), 2'($urandom_range(0, 3)));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2);
        @(negedge clk);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
